// File: rtl/wiener_frame_streamer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wiener_stream_pkg
// Function : Shared FSM state encoding, frame-header sync bytes and the
//            bytes-per-pixel helper for the Wiener frame streamer.
// Revision : 1.0 - initial release
// ============================================================================
package wiener_stream_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_HDR   = 4'd1,
        ST_ADDR  = 4'd2,
        ST_WAIT  = 4'd3,
        ST_LATCH = 4'd4,
        ST_SEND  = 4'd5,
        ST_GAP   = 4'd6,
        ST_NEXT  = 4'd7,
        ST_DONE  = 4'd8
    } state_t;

    localparam logic [7:0] HDR_SYNC0 = 8'hA5;
    localparam logic [7:0] HDR_SYNC1 = 8'h5A;

    function automatic int nbytes(input int pix_w);
        return (pix_w + 7) / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wiener_frame_streamer_if.sv
`default_nettype none
// ============================================================================
// Module   : wiener_frame_streamer_if
// Function : Control, ROM and UART signals of the frame streamer; the master
//            modport is the streamer, the slave modport its environment.
// Revision : 1.0 - initial release
// ============================================================================
interface wiener_frame_streamer_if #(
    parameter int ADDR_W = 17,
    parameter int PIX_W  = 8
);
    logic              start;
    logic              bypass;
    logic [ADDR_W-1:0] rom_addr;
    logic [PIX_W-1:0]  rom_q;
    logic [PIX_W-1:0]  filt_q;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              tx_busy;
    logic [15:0]       src_x;
    logic [15:0]       src_y;
    logic [PIX_W-1:0]  pixel_reg;
    logic              active;
    logic              frame_done;

    modport master (
        input  start, bypass, rom_q, filt_q, tx_busy,
        output rom_addr, tx_data, tx_start, src_x, src_y, pixel_reg, active, frame_done
    );

    modport slave (
        output start, bypass, rom_q, filt_q, tx_busy,
        input  rom_addr, tx_data, tx_start, src_x, src_y, pixel_reg, active, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/wiener_frame_streamer_byte_tx.sv
`default_nettype none
// ============================================================================
// Module   : stream_byte_tx
// Function : Serialises one NB-byte word MSB byte first over a UART
//            start/busy handshake; pulses o_done after the last strobe.
// Revision : 1.0 - initial release
// ============================================================================
module stream_byte_tx
    import wiener_stream_pkg::*;
#(
    parameter  int NB    = 1,
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1
) (
    input  wire logic              pclk,
    input  wire logic              reset_n,
    input  wire logic              i_load,
    input  wire logic [NB*8-1:0]   i_word,
    input  wire logic [IDX_W-1:0]  i_first,
    input  wire logic              i_tx_busy,
    output logic                   o_done,
    output logic [7:0]             o_tx_data,
    output logic                   o_tx_start
);
    state_t            r_state;
    logic [NB*8-1:0]   r_word;
    logic [IDX_W-1:0]  r_idx;
    logic [7:0]        w_byte;

    assign w_byte = 8'(r_word >> {r_idx, 3'b000});

    // Busy is not looked at in GAP: the UART only raises it a cycle after the strobe.
    always_ff @(posedge pclk) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_word     <= '0;
            r_idx      <= '0;
            o_done     <= 1'b0;
            o_tx_data  <= 8'h00;
            o_tx_start <= 1'b0;
        end else begin
            o_done     <= 1'b0;
            o_tx_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_load) begin
                        r_word  <= i_word;
                        r_idx   <= i_first;
                        r_state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (!i_tx_busy) begin
                        o_tx_data  <= w_byte;
                        o_tx_start <= 1'b1;
                        r_state    <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (r_idx == '0) begin
                        o_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_idx   <= r_idx - 1'b1;
                        r_state <= ST_SEND;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/wiener_frame_streamer.sv
`default_nettype none
// ============================================================================
// Module   : wiener_frame_streamer
// Function : Raster-scans a ROM frame (with decimation), selects raw or
//            Wiener-filtered pixels and streams them byte-wise to a UART.
//            Optional 3-byte frame header: define WIENER_STREAM_FRAME_HDR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module wiener_frame_streamer
    import wiener_stream_pkg::*;
#(
    parameter  int SRC_W      = 320,
    parameter  int SRC_H      = 240,
    parameter  int PIX_W      = 8,
    parameter  int ROM_LAT    = 1,
    parameter  int STEP       = 1,
    parameter  int CONTINUOUS = 0,
    localparam int ADDR_W     = $clog2(SRC_W * SRC_H),
    localparam int NB         = nbytes(PIX_W),
    localparam int WORD_W     = NB * 8,
    localparam int IDX_W      = (NB > 1) ? $clog2(NB) : 1
) (
    input  wire logic                  pclk,
    input  wire logic                  reset_n,
    wiener_frame_streamer_if.master    bus
);
    localparam logic [ADDR_W-1:0] c_ROW_INC = ADDR_W'(STEP * SRC_W);

    state_t              r_state;
    logic [15:0]         r_x;
    logic [15:0]         r_y;
    logic [ADDR_W-1:0]   r_row_base;
    logic [2:0]          r_lat;
    logic                r_load;
    logic [WORD_W-1:0]   r_word;
    logic [IDX_W-1:0]    r_first;
    logic [ADDR_W-1:0]   r_rom_addr;
    logic [15:0]         r_src_x;
    logic [15:0]         r_src_y;
    logic [PIX_W-1:0]    r_pixel;
    logic                r_active;
    logic                r_frame_done;
    logic                w_done;
    logic                w_begin;
    logic [PIX_W-1:0]    w_pix;
    logic [WORD_W-1:0]   w_word;
    logic [16:0]         w_x_next;
    logic [16:0]         w_y_next;
`ifdef WIENER_STREAM_FRAME_HDR_EN
    logic [7:0]          r_frame_cnt;
    logic [1:0]          r_hdr_idx;
    logic                r_in_hdr;
    logic [7:0]          w_hdr_byte;

    always_comb begin
        case (r_hdr_idx)
            2'd0:    w_hdr_byte = HDR_SYNC0;
            2'd1:    w_hdr_byte = HDR_SYNC1;
            default: w_hdr_byte = r_frame_cnt;
        endcase
    end
`endif

    assign w_pix    = bus.bypass ? bus.rom_q : bus.filt_q;
    assign w_x_next = {1'b0, r_x} + 17'(STEP);
    assign w_y_next = {1'b0, r_y} + 17'(STEP);
    assign w_begin  = (r_state == ST_IDLE && bus.start) ||
                      (r_state == ST_DONE && CONTINUOUS != 0);

    always_comb begin
        w_word              = '0;
        w_word[PIX_W-1:0]   = w_pix;
    end

    always_ff @(posedge pclk) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_x          <= '0;
            r_y          <= '0;
            r_row_base   <= '0;
            r_lat        <= '0;
            r_load       <= 1'b0;
            r_word       <= '0;
            r_first      <= '0;
            r_rom_addr   <= '0;
            r_src_x      <= '0;
            r_src_y      <= '0;
            r_pixel      <= '0;
            r_active     <= 1'b0;
            r_frame_done <= 1'b0;
`ifdef WIENER_STREAM_FRAME_HDR_EN
            r_frame_cnt  <= '0;
            r_hdr_idx    <= '0;
            r_in_hdr     <= 1'b0;
`endif
        end else begin
            r_load       <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: ;
`ifdef WIENER_STREAM_FRAME_HDR_EN
                ST_HDR: begin
                    r_load    <= 1'b1;
                    r_word    <= WORD_W'(w_hdr_byte);
                    r_first   <= '0;
                    r_hdr_idx <= r_hdr_idx + 2'd1;
                    r_in_hdr  <= 1'b1;
                    r_state   <= ST_SEND;
                end
`endif
                ST_ADDR: begin
                    r_rom_addr <= r_row_base + ADDR_W'(r_x);
                    r_lat      <= '0;
                    r_state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_lat == 3'(ROM_LAT - 1)) r_state <= ST_LATCH;
                    else                          r_lat   <= r_lat + 3'd1;
                end
                ST_LATCH: begin
                    r_pixel <= w_pix;
                    r_src_x <= r_x;
                    r_src_y <= r_y;
                    r_load  <= 1'b1;
                    r_word  <= w_word;
                    r_first <= IDX_W'(NB - 1);
                    r_state <= ST_SEND;
                end
                ST_SEND: begin
                    if (w_done) begin
`ifdef WIENER_STREAM_FRAME_HDR_EN
                        if (r_in_hdr) begin
                            r_in_hdr <= 1'b0;
                            r_state  <= (r_hdr_idx == 2'd3) ? ST_ADDR : ST_HDR;
                        end else
`endif
                        r_state <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    // Row address advances by a constant stride, so no multiplier is needed.
                    if (w_x_next >= 17'(SRC_W)) begin
                        r_x <= '0;
                        if (w_y_next >= 17'(SRC_H)) begin
                            r_frame_done <= 1'b1;
                            r_active     <= 1'b0;
                            r_state      <= ST_DONE;
                        end else begin
                            r_y        <= w_y_next[15:0];
                            r_row_base <= r_row_base + c_ROW_INC;
                            r_state    <= ST_ADDR;
                        end
                    end else begin
                        r_x     <= w_x_next[15:0];
                        r_state <= ST_ADDR;
                    end
                end
                ST_DONE: begin
`ifdef WIENER_STREAM_FRAME_HDR_EN
                    r_frame_cnt <= r_frame_cnt + 8'd1;
`endif
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_begin) begin
                r_x        <= '0;
                r_y        <= '0;
                r_row_base <= '0;
                r_active   <= 1'b1;
`ifdef WIENER_STREAM_FRAME_HDR_EN
                r_hdr_idx  <= '0;
                r_state    <= ST_HDR;
`else
                r_state    <= ST_ADDR;
`endif
            end
        end
    end

    stream_byte_tx #(.NB(NB)) u_byte_tx (
        .pclk       (pclk),
        .reset_n    (reset_n),
        .i_load     (r_load),
        .i_word     (r_word),
        .i_first    (r_first),
        .i_tx_busy  (bus.tx_busy),
        .o_done     (w_done),
        .o_tx_data  (bus.tx_data),
        .o_tx_start (bus.tx_start)
    );

    assign bus.rom_addr   = r_rom_addr;
    assign bus.src_x      = r_src_x;
    assign bus.src_y      = r_src_y;
    assign bus.pixel_reg  = r_pixel;
    assign bus.active     = r_active;
    assign bus.frame_done = r_frame_done;
endmodule
`default_nettype wire

// File: tb/tb_wiener_frame_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_wiener_frame_streamer
// Function : Scoreboard bench for two streamer configurations (4x2 8-bit
//            single-shot; 5x3 12-bit decimated continuous).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wiener_frame_streamer;

    typedef struct {
        logic [7:0] d;
        bit         pos;
        int         addr;
        int         x;
        int         y;
    } exp_t;

    logic clk = 1'b0;
    logic rst0_n;
    logic rst1_n;
    always #5 clk = ~clk;

    wiener_frame_streamer_if #(.ADDR_W(3), .PIX_W(8))  b0();
    wiener_frame_streamer_if #(.ADDR_W(4), .PIX_W(12)) b1();

    wiener_frame_streamer #(.SRC_W(4), .SRC_H(2), .PIX_W(8), .ROM_LAT(1),
                            .STEP(1), .CONTINUOUS(0)) dut0 (
        .pclk(clk), .reset_n(rst0_n), .bus(b0));

    wiener_frame_streamer #(.SRC_W(5), .SRC_H(3), .PIX_W(12), .ROM_LAT(3),
                            .STEP(2), .CONTINUOUS(1)) dut1 (
        .pclk(clk), .reset_n(rst1_n), .bus(b1));

    // ROM mocks: ROM0[k]=k (1-cycle), ROM1[k]=0xAB0+k (3-cycle); filtered = inverted raw
    logic [2:0] r0;
    logic [3:0] p1a, p1b, p1c;
    always @(posedge clk) begin
        r0  <= b0.rom_addr;
        p1a <= b1.rom_addr;
        p1b <= p1a;
        p1c <= p1b;
    end
    assign b0.rom_q  = {5'b0, r0};
    assign b0.filt_q = ~b0.rom_q;
    assign b1.rom_q  = 12'hAB0 + {8'h00, p1c};
    assign b1.filt_q = ~b1.rom_q;

    // UART mocks: busy for 5 cycles starting the cycle after each strobe
    int busy0 = 0;
    int busy1 = 0;
    always @(posedge clk) begin
        if (b0.tx_start) busy0 <= 5; else if (busy0 != 0) busy0 <= busy0 - 1;
        if (b1.tx_start) busy1 <= 5; else if (busy1 != 0) busy1 <= busy1 - 1;
    end
    assign b0.tx_busy = (busy0 != 0);
    assign b1.tx_busy = (busy1 != 0);

    exp_t q0[$];
    exp_t q1[$];
    int checks   = 0;
    int fails    = 0;
    int strobes0 = 0;
    int strobes1 = 0;
    int done0    = 0;
    int done1    = 0;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int u, input logic [7:0] d, input bit pos,
                        input int a, input int x, input int y);
        exp_t e;
        e.d = d; e.pos = pos; e.addr = a; e.x = x; e.y = y;
        if (u == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic mon_byte(input int u, input logic [7:0] d, input logic [31:0] a,
                            input logic [15:0] x, input logic [15:0] y);
        exp_t e;
        if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
            checks++;
            fails++;
            $display("FAIL u%0d_unexpected_strobe: got tx_data 0x%0h expected no strobe", u, d);
        end else begin
            e = (u == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("u%0d_tx_data", u), {24'h0, d}, int'(e.d));
            if (e.pos) begin
                chk($sformatf("u%0d_rom_addr", u), a, e.addr);
                chk($sformatf("u%0d_src_x", u), {16'h0, x}, e.x);
                chk($sformatf("u%0d_src_y", u), {16'h0, y}, e.y);
            end
        end
    endtask

    always @(negedge clk) begin
        if (b0.frame_done) done0++;
        if (b1.frame_done) done1++;
        if (b0.tx_start) begin
            strobes0++;
            mon_byte(0, b0.tx_data, {29'h0, b0.rom_addr}, b0.src_x, b0.src_y);
        end
        if (b1.tx_start) begin
            strobes1++;
            mon_byte(1, b1.tx_data, {28'h0, b1.rom_addr}, b1.src_x, b1.src_y);
        end
    end

    function automatic int cur(input int sel);
        case (sel)
            0:       return strobes0;
            1:       return done0;
            default: return done1;
        endcase
    endfunction

    task automatic wait_until(input int sel, input int target, input string name);
        int t;
        t = 0;
        while (cur(sel) < target && t < 5000) begin
            @(posedge clk); #2;
            t++;
        end
        checks++;
        if (cur(sel) < target) begin
            fails++;
            $display("FAIL %s_timeout: count %0d expected %0d", name, cur(sel), target);
        end
    endtask

    int u1_addr[6] = '{0, 2, 4, 10, 12, 14};
    int u1_x[6]    = '{0, 2, 4, 0, 2, 4};
    int u1_y[6]    = '{0, 0, 0, 2, 2, 2};
    logic [7:0] u1_lo[6] = '{8'hB0, 8'hB2, 8'hB4, 8'hBA, 8'hBC, 8'hBE};

    initial begin
        rst0_n = 1'b0; rst1_n = 1'b0;
        b0.start = 1'b0; b0.bypass = 1'b1;
        b1.start = 1'b0; b1.bypass = 1'b1;
        repeat (3) @(posedge clk); #2;

        chk("rst_active",     {31'h0, b0.active},     0);
        chk("rst_tx_start",   {31'h0, b0.tx_start},   0);
        chk("rst_frame_done", {31'h0, b0.frame_done}, 0);
        chk("rst_rom_addr",   {29'h0, b0.rom_addr},   0);
        chk("rst_tx_data",    {24'h0, b0.tx_data},    0);
        chk("rst_u1_active",  {31'h0, b1.active},     0);

        // Frame A: raw for pixels 0..2, filtered (inverted) from pixel 3 on
        rst0_n = 1'b1;
        @(posedge clk); #2;
        push(0, 8'h00, 1, 0, 0, 0); push(0, 8'h01, 1, 1, 1, 0);
        push(0, 8'h02, 1, 2, 2, 0); push(0, 8'hFC, 1, 3, 3, 0);
        push(0, 8'hFB, 1, 4, 0, 1); push(0, 8'hFA, 1, 5, 1, 1);
        push(0, 8'hF9, 1, 6, 2, 1); push(0, 8'hF8, 1, 7, 3, 1);
        b0.start = 1'b1; @(posedge clk); #2; b0.start = 1'b0;
        chk("u0_active_after_start", {31'h0, b0.active}, 1);
        wait_until(0, 3, "u0_third_strobe");
        b0.bypass = 1'b0;
        wait_until(1, 1, "u0_frame_a_done");
        @(posedge clk); #2;
        chk("u0_active_after_done", {31'h0, b0.active}, 0);
        chk("u0_done_count_a", done0, 1);
        chk("u0_strobes_a", strobes0, 8);
        chk("u0_queue_empty_a", q0.size(), 0);

        // Frame B: reset while the 3rd byte is in flight
        b0.bypass = 1'b1;
        for (int k = 0; k < 8; k++) push(0, 8'(k), 1, k, k % 4, k / 4);
        b0.start = 1'b1; @(posedge clk); #2; b0.start = 1'b0;
        wait_until(0, 11, "u0_reset_point");
        rst0_n = 1'b0;
        @(posedge clk); #2;
        q0.delete();
        chk("mid_rst_tx_start",   {31'h0, b0.tx_start},   0);
        chk("mid_rst_tx_data",    {24'h0, b0.tx_data},    0);
        chk("mid_rst_rom_addr",   {29'h0, b0.rom_addr},   0);
        chk("mid_rst_pixel_reg",  {24'h0, b0.pixel_reg},  0);
        chk("mid_rst_src_x",      {16'h0, b0.src_x},      0);
        chk("mid_rst_active",     {31'h0, b0.active},     0);
        chk("mid_rst_frame_done", {31'h0, b0.frame_done}, 0);
        repeat (2) @(posedge clk); #2;
        rst0_n = 1'b1;
        repeat (20) @(posedge clk); #2;
        chk("u0_no_strobe_after_rst", strobes0, 11);

        // Frame C: restart resends from address 0
        for (int k = 0; k < 8; k++) push(0, 8'(k), 1, k, k % 4, k / 4);
        b0.start = 1'b1; @(posedge clk); #2; b0.start = 1'b0;
        wait_until(1, 2, "u0_frame_c_done");
        @(posedge clk); #2;
        chk("u0_strobes_c", strobes0, 19);
        chk("u0_queue_empty_c", q0.size(), 0);
        chk("u0_active_after_c", {31'h0, b0.active}, 0);

        // U1: 12-bit pixels, STEP=2, continuous; start held high throughout
        for (int f = 0; f < 2; f++) begin
`ifdef WIENER_STREAM_FRAME_HDR_EN
            push(1, 8'hA5, 0, 0, 0, 0);
            push(1, 8'h5A, 0, 0, 0, 0);
            push(1, 8'(f), 0, 0, 0, 0);
`endif
            for (int p = 0; p < 6; p++) begin
                push(1, 8'h0A, 1, u1_addr[p], u1_x[p], u1_y[p]);
                push(1, u1_lo[p], 1, u1_addr[p], u1_x[p], u1_y[p]);
            end
        end
        rst1_n = 1'b1;
        b1.start = 1'b1;
        wait_until(2, 2, "u1_two_frames");
        rst1_n = 1'b0;
        b1.start = 1'b0;
        @(posedge clk); #2;
        chk("u1_done_count", done1, 2);
`ifdef WIENER_STREAM_FRAME_HDR_EN
        chk("u1_strobes", strobes1, 30);
`else
        chk("u1_strobes", strobes1, 24);
`endif
        chk("u1_queue_empty", q1.size(), 0);
        chk("u1_rst_tx_start", {31'h0, b1.tx_start}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
